// File: rtl/oled_text_fmt.sv
// oled_text_fmt: turns hex-print requests into ASCII in a 4x16 shadow buffer
// and publishes a tear-free snapshot of it to the OLED controller on frame-done.
module oled_text_fmt #(
   parameter logic [7:0] BLANK_CHAR = 8'h20,
   parameter bit         UPPER_HEX  = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [1:0]   wr_row,
   input  logic [3:0]   wr_col,
   input  logic [2:0]   wr_ndig,
   input  logic [31:0]  wr_value,
   input  logic         clr,
   input  logic         print_fin,
   output logic [511:0] char_data,
   output logic         busy,
   output logic [7:0]   snap_cnt
);

   typedef enum logic [1:0] {IDLE, CONV, CLEAR} state_t;

   state_t state, state_next;

   // Element 63-i holds char i, so the packed shadow lines up with char_data.
   logic [63:0][7:0] shadow;

   logic [1:0]  row;
   logic [3:0]  col;
   logic [31:0] value;
   logic [3:0]  n;
   logic [2:0]  k;
   logic [5:0]  idx;
   logic        pending;
   logic        print_fin_d;

   logic        accept;
   logic        clear_start;
   logic        fin_rise;
   logic        snap_take;
   logic [2:0]  nib_sel;
   logic [3:0]  nib;
   logic [7:0]  ascii;
   logic [4:0]  col_pos;
   logic        conv_write;
   logic [5:0]  conv_addr;

   // Handshake, snapshot trigger and nibble-to-ASCII datapath.
   always_comb begin
      wr_ready    = (state == IDLE) && !clr;
      clear_start = (state == IDLE) && clr;
      accept      = wr_ready && wr_valid;
      fin_rise    = print_fin && !print_fin_d;
      snap_take   = pending && (state == IDLE);
      busy        = (state != IDLE) || pending;
      // n is 1..8; for n=8 the low bits are 0 and the 3-bit wrap still gives 7-k.
      nib_sel     = n[2:0] - 3'd1 - k;
      nib         = value[{nib_sel, 2'b00} +: 4];
      if (nib < 4'd10) begin
         ascii = 8'h30 + {4'h0, nib};
      end else begin
         ascii = (UPPER_HEX ? 8'h37 : 8'h57) + {4'h0, nib};
      end
      col_pos     = {1'b0, col} + {2'b00, k};
      conv_write  = (state == CONV) && !col_pos[4];
      conv_addr   = {row, col_pos[3:0]};
   end

   // Next-state selection; clear takes priority over a print request.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (clear_start) begin
               state_next = CLEAR;
            end else if (accept) begin
               state_next = CONV;
            end
         end
         CONV: begin
            if ({1'b0, k} == (n - 4'd1)) begin
               state_next = IDLE;
            end
         end
         CLEAR: begin
            if (idx == 6'd63) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request latching, shadow writes, and snapshot publishing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row         <= '0;
         col         <= '0;
         value       <= '0;
         n           <= 4'd8;
         k           <= '0;
         idx         <= '0;
         shadow      <= {64{BLANK_CHAR}};
         char_data   <= {64{BLANK_CHAR}};
         snap_cnt    <= '0;
         pending     <= 1'b0;
         print_fin_d <= 1'b0;
      end else begin
         print_fin_d <= print_fin;
         // A new edge wins over the clear, so an edge during a snapshot is kept.
         pending     <= fin_rise | (pending & ~snap_take);
         if (snap_take) begin
            char_data <= shadow;
            snap_cnt  <= snap_cnt + 8'd1;
         end
         case (state)
            IDLE: begin
               if (clear_start) begin
                  idx <= '0;
               end else if (accept) begin
                  row   <= wr_row;
                  col   <= wr_col;
                  value <= wr_value;
                  n     <= (wr_ndig == 3'd0) ? 4'd8 : {1'b0, wr_ndig};
                  k     <= '0;
               end
            end
            CONV: begin
               if (conv_write) begin
                  shadow[6'd63 - conv_addr] <= ascii;
               end
               k <= k + 3'd1;
            end
            CLEAR: begin
               shadow[6'd63 - idx] <= BLANK_CHAR;
               idx <= idx + 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_oled_text_fmt.sv
// Scoreboard bench for oled_text_fmt: the stimulus side pushes the expected
// frame for each print_fin pulse, a monitor pops it when snap_cnt moves.
module tb_oled_text_fmt;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         wr_valid = 1'b0;
   logic [1:0]   wr_row = '0;
   logic [3:0]   wr_col = '0;
   logic [2:0]   wr_ndig = '0;
   logic [31:0]  wr_value = '0;
   logic         clr = 1'b0;
   logic         print_fin = 1'b0;
   logic         wr_ready;
   logic [511:0] char_data;
   logic         busy;
   logic [7:0]   snap_cnt;
   logic         lc_wr_ready;
   logic [511:0] lc_char_data;
   logic         lc_busy;
   logic [7:0]   lc_snap_cnt;

   typedef struct packed {
      logic [511:0] frame;
      logic [7:0]   cnt;
   } snap_t;

   snap_t            exp_q[$];
   snap_t            exp_item;
   logic [63:0][7:0] model;
   logic [7:0]       exp_snap;
   logic [7:0]       last_snap;
   int               checks = 0;
   int               passed = 0;

   oled_text_fmt dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_row(wr_row), .wr_col(wr_col), .wr_ndig(wr_ndig), .wr_value(wr_value),
      .clr(clr), .print_fin(print_fin), .char_data(char_data),
      .busy(busy), .snap_cnt(snap_cnt)
   );

   // Lowercase build fed the same stimulus.
   oled_text_fmt #(.UPPER_HEX(1'b0)) dut_lc (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(lc_wr_ready),
      .wr_row(wr_row), .wr_col(wr_col), .wr_ndig(wr_ndig), .wr_value(wr_value),
      .clr(clr), .print_fin(print_fin), .char_data(lc_char_data),
      .busy(lc_busy), .snap_cnt(lc_snap_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [511:0] actual,
                              input logic [511:0] expected);
      checks++;
      if (actual === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every snapshot the DUT publishes is matched against the queue head.
   always @(negedge clk) begin
      if (rst) begin
         last_snap = 8'd0;
      end else if (snap_cnt !== last_snap) begin
         last_snap = snap_cnt;
         if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_snapshot: got snap_cnt %0d, expected no snapshot", snap_cnt);
         end else begin
            exp_item = exp_q.pop_front();
            checkOutput("snapshot_frame", char_data, exp_item.frame);
            checkOutput("snapshot_count", 512'(snap_cnt), 512'(exp_item.cnt));
         end
      end
   end

   // Present one print request (IDLE assumed) and record the hand-given characters.
   task automatic applyStimulus(input logic [1:0] row, input logic [3:0] col,
                                input logic [2:0] ndig, input logic [31:0] value,
                                input logic [63:0] str);
      int n;
      wr_row   = row;
      wr_col   = col;
      wr_ndig  = ndig;
      wr_value = value;
      wr_valid = 1'b1;
      @(posedge clk);
      #1 wr_valid = 1'b0;
      n = (ndig == 3'd0) ? 8 : int'(ndig);
      for (int k = 0; k < n; k++) begin
         if (int'(col) + k <= 15) begin
            model[63 - (int'(row) * 16 + int'(col) + k)] = str[(n - 1 - k) * 8 +: 8];
         end
      end
   endtask

   // Count cycles until wr_ready returns; bounded so a stuck DUT still fails cleanly.
   task automatic waitReady(input string name, input int expected, input int elapsed);
      int cnt = elapsed;
      while (!wr_ready && cnt < 200) begin
         @(posedge clk);
         #1 cnt++;
      end
      checkOutput(name, 512'(cnt), 512'(expected));
   endtask

   // One-cycle print_fin pulse; the current model is the frame that must appear.
   task automatic pulseFin(input string name);
      exp_snap = exp_snap + 8'd1;
      exp_q.push_back('{frame: model, cnt: exp_snap});
      print_fin = 1'b1;
      @(posedge clk);
      #1 print_fin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (busy) begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput(name, 512'(busy), 512'(1'b0));
   endtask

   initial begin
      model    = {64{8'h20}};
      exp_snap = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", 512'(busy), 512'(1'b0));
      checkOutput("reset_wr_ready", 512'(wr_ready), 512'(1'b1));
      checkOutput("reset_snap_cnt", 512'(snap_cnt), 512'(8'd0));
      checkOutput("reset_char_data", char_data, {64{8'h20}});
      @(posedge clk);
      #1;

      // Blank frame straight out of reset.
      pulseFin("busy_after_blank_snap");

      // Full 8-digit write on row 1.
      applyStimulus(2'd1, 4'd0, 3'd0, 32'hDEADBEEF, "DEADBEEF");
      waitReady("conv_latency_8", 8, 0);
      pulseFin("busy_after_deadbeef");

      // Write that runs off the right edge: only "12" survives at chars 62,63.
      applyStimulus(2'd3, 4'd14, 3'd4, 32'h00001234, "1234");
      waitReady("conv_latency_4", 4, 0);
      pulseFin("busy_after_edge_write");
      checkOutput("no_wrap_row0", 512'(char_data[511:496]), 512'(16'h2020));
      checkOutput("edge_chars_62_63", 512'(char_data[15:0]), 512'(16'h3132));

      // print_fin rises two cycles into a conversion and stays high.
      applyStimulus(2'd2, 4'd0, 3'd0, 32'h01234567, "01234567");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      exp_snap = exp_snap + 8'd1;
      exp_q.push_back('{frame: model, cnt: exp_snap});
      print_fin = 1'b1;
      waitReady("conv_latency_with_fin", 8, 2);
      repeat (4) @(posedge clk);
      #1 print_fin = 1'b0;
      checkOutput("busy_after_deferred_snap", 512'(busy), 512'(1'b0));

      // clr and wr_valid together: clear wins and the request is refused.
      clr      = 1'b1;
      wr_valid = 1'b1;
      wr_row   = 2'd0;
      wr_col   = 4'd0;
      wr_ndig  = 3'd2;
      wr_value = 32'h000000FF;
      #1 checkOutput("wr_ready_during_clr", 512'(wr_ready), 512'(1'b0));
      @(posedge clk);
      #1 clr = 1'b0;
      wr_valid = 1'b0;
      model = {64{8'h20}};
      waitReady("clear_latency", 64, 0);
      pulseFin("busy_after_clear_snap");

      // Hex letters in both builds.
      applyStimulus(2'd0, 4'd0, 3'd2, 32'h000000AB, "AB");
      waitReady("conv_latency_2", 2, 0);
      pulseFin("busy_after_ab");
      checkOutput("lowercase_hex", 512'(lc_char_data[511:496]), 512'(16'h6162));

      // Reset in the middle of a conversion.
      applyStimulus(2'd1, 4'd4, 3'd0, 32'hCAFEF00D, "CAFEF00D");
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("midconv_reset_busy", 512'(busy), 512'(1'b0));
      checkOutput("midconv_reset_wr_ready", 512'(wr_ready), 512'(1'b1));
      checkOutput("midconv_reset_char_data", char_data, {64{8'h20}});
      checkOutput("midconv_reset_snap_cnt", 512'(snap_cnt), 512'(8'd0));
      @(posedge clk);
      #1 rst = 1'b0;
      model    = {64{8'h20}};
      exp_snap = 8'd0;
      pulseFin("busy_after_post_reset_snap");

      repeat (4) @(posedge clk);
      #1 checkOutput("scoreboard_drained", 512'(exp_q.size()), 512'(0));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got %0d checks so far", checks);
      $fatal(1, "[TB] timeout");
   end

endmodule
